// File: rtl/jogo_sequencia_param.sv
// jogo_sequencia_param: parametrised sequence-memory game core.
// Grows a random sequence one element per round, replays it on N one-hot
// LEDs and checks the player's repetition with a per-press timeout.
// Optional feature macro JOGO_MODO2_EN: the player records each new element
// (state GRAVA) instead of the LFSR supplying it.
module jogo_sequencia_param #(
  parameter int N         = 4,
  parameter int DEPTH     = 16,
  parameter int T_SHOW    = 500,
  parameter int T_TIMEOUT = 5000,
  localparam int W        = $clog2(N),
  localparam int RW       = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic [N-1:0]  botoes,
  input  logic          nivel,
  output logic [N-1:0]  leds,
  output logic          vez_jogador,
  output logic          ganhou,
  output logic          perdeu,
  output logic          timeout,
  output logic          pronto,
  output logic [RW-1:0] rodada,
  output logic [4:0]    db_estado
);

  localparam int T_MAX = (T_SHOW > T_TIMEOUT) ? T_SHOW : T_TIMEOUT;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [4:0] {
    INICIAL  = 5'd0,
    PREPARA  = 5'd1,
    MOSTRA   = 5'd2,
    APAGA    = 5'd3,
    ESPERA   = 5'd4,
    REGISTRA = 5'd5,
    COMPARA  = 5'd6,
    SOLTA    = 5'd7,
    PROXIMA  = 5'd8,
    GANHOU   = 5'd9,
    PERDEU   = 5'd10,
    GRAVA    = 5'd11
  } estado_t;

  estado_t estado, estado_prox;

  logic [15:0]   lfsr;
  logic          lfsr_fb;
  logic [TW-1:0] contador, contador_prox;
  logic [RW-1:0] addr, addr_prox, rodada_prox, ultima, fim_exib;
  logic          nivel_r, nivel_prox;
  logic [N-1:0]  jogada, jogada_prox, botoes_ant;
  logic          timeout_prox, pronto_prox;

  logic [W-1:0]  ram [DEPTH];
  logic          ram_we;
  logic [RW-1:0] ram_wa;
  logic [W-1:0]  ram_wd;

  logic [W-1:0]  esperado;
  logic [N-1:0]  esperado_oh;
  logic          show_fim, tempo_fim, aperto, acerto;

  assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign esperado    = ram[addr];
  assign esperado_oh = N'(1) << esperado;
  assign show_fim    = (contador == TW'(T_SHOW - 1));
  assign tempo_fim   = (contador == TW'(T_TIMEOUT - 1));
  assign aperto      = (botoes != '0) && (botoes_ant == '0);
  assign acerto      = (jogada == esperado_oh);
  assign ultima      = nivel_r ? RW'(DEPTH - 1) : RW'(DEPTH / 2 - 1);

`ifdef JOGO_MODO2_EN
  // Round r only replays the r elements already recorded, so display stops one short.
  assign fim_exib = rodada - RW'(1);

  logic [W-1:0] jogada_idx;
  logic         jogada_unica;

  // One-hot to index encoder for the recorded press
  always_comb begin
    jogada_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (jogada[i]) jogada_idx = W'(i);
    end
  end

  assign jogada_unica = (jogada != '0) && ((jogada & (jogada - N'(1))) == '0);
`else
  assign fim_exib = rodada;
`endif

  assign ganhou    = (estado == GANHOU);
  assign perdeu    = (estado == PERDEU);
  assign db_estado = estado;

  // Next-state, datapath next values and combinational outputs
  always_comb begin
    estado_prox   = estado;
    contador_prox = '0;
    addr_prox     = addr;
    rodada_prox   = rodada;
    nivel_prox    = nivel_r;
    jogada_prox   = jogada;
    timeout_prox  = timeout;
    ram_we        = 1'b0;
    ram_wa        = addr;
    ram_wd        = lfsr[W-1:0];
    leds          = '0;
    vez_jogador   = 1'b0;
    case (estado)
      INICIAL, GANHOU, PERDEU: begin
        if (iniciar) begin
          estado_prox  = PREPARA;
          timeout_prox = 1'b0;
        end
      end
      PREPARA: begin
        nivel_prox  = nivel;
        rodada_prox = '0;
        addr_prox   = '0;
`ifdef JOGO_MODO2_EN
        estado_prox = ESPERA;
`else
        ram_we      = 1'b1;
        ram_wa      = '0;
        estado_prox = MOSTRA;
`endif
      end
      MOSTRA: begin
        leds = esperado_oh;
        if (show_fim) estado_prox = APAGA;
        else          contador_prox = contador + TW'(1);
      end
      APAGA: begin
        if (show_fim) begin
          if (addr == fim_exib) begin
            addr_prox   = '0;
            estado_prox = ESPERA;
          end else begin
            addr_prox   = addr + RW'(1);
            estado_prox = MOSTRA;
          end
        end else begin
          contador_prox = contador + TW'(1);
        end
      end
      ESPERA: begin
        leds          = botoes;
        vez_jogador   = 1'b1;
        contador_prox = contador + TW'(1);
        if (aperto) begin
          estado_prox = REGISTRA;
        end else if (tempo_fim) begin
          estado_prox  = PERDEU;
          timeout_prox = 1'b1;
        end
      end
      REGISTRA: begin
        jogada_prox = botoes;
`ifdef JOGO_MODO2_EN
        estado_prox = (addr == rodada) ? GRAVA : COMPARA;
`else
        estado_prox = COMPARA;
`endif
      end
      COMPARA: begin
        if (!acerto) begin
          estado_prox = PERDEU;
        end else if (addr != rodada) begin
          addr_prox   = addr + RW'(1);
          estado_prox = SOLTA;
        end else if (rodada == ultima) begin
          estado_prox = GANHOU;
        end else begin
          estado_prox = PROXIMA;
        end
      end
      // Timeout keeps counting here so the budget spans press-to-press.
      SOLTA: begin
        contador_prox = contador + TW'(1);
        if (botoes == '0) begin
          estado_prox = ESPERA;
        end else if (tempo_fim) begin
          estado_prox  = PERDEU;
          timeout_prox = 1'b1;
        end
      end
      PROXIMA: begin
        if (botoes == '0) begin
          rodada_prox = (rodada == RW'(DEPTH - 1)) ? rodada : rodada + RW'(1);
          addr_prox   = '0;
          estado_prox = MOSTRA;
`ifndef JOGO_MODO2_EN
          ram_we      = 1'b1;
          ram_wa      = rodada_prox;
`endif
        end
      end
`ifdef JOGO_MODO2_EN
      GRAVA: begin
        if (!jogada_unica) begin
          estado_prox = PERDEU;
        end else begin
          ram_we      = 1'b1;
          ram_wa      = rodada;
          ram_wd      = jogada_idx;
          estado_prox = (rodada == ultima) ? GANHOU : PROXIMA;
        end
      end
`endif
      default: estado_prox = INICIAL;
    endcase
    pronto_prox = ((estado_prox == GANHOU) || (estado_prox == PERDEU)) &&
                  !((estado == GANHOU) || (estado == PERDEU));
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= estado_prox;
  end

  // Datapath registers: LFSR, shared show/timeout counter, indices and flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr       <= 16'hACE1;
      contador   <= '0;
      addr       <= '0;
      rodada     <= '0;
      nivel_r    <= 1'b0;
      jogada     <= '0;
      botoes_ant <= '0;
      timeout    <= 1'b0;
      pronto     <= 1'b0;
    end else begin
      lfsr       <= {lfsr[14:0], lfsr_fb};
      contador   <= contador_prox;
      addr       <= addr_prox;
      rodada     <= rodada_prox;
      nivel_r    <= nivel_prox;
      jogada     <= jogada_prox;
      botoes_ant <= botoes;
      timeout    <= timeout_prox;
      pronto     <= pronto_prox;
    end
  end

  // Sequence memory: synchronous write, asynchronous read, never cleared
  always_ff @(posedge clock) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
  end

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Self-checking bench for jogo_sequencia_param (N=4, DEPTH=4, T_SHOW=4,
// T_TIMEOUT=20). Expected per-cycle state/LED values go into a scoreboard
// queue when stimulus is applied and are compared cycle by cycle.
module tb_jogo_sequencia_param;

  localparam int N         = 4;
  localparam int DEPTH     = 4;
  localparam int T_SHOW    = 4;
  localparam int T_TIMEOUT = 20;

  localparam logic [4:0] S_INI   = 5'd0;
  localparam logic [4:0] S_PREP  = 5'd1;
  localparam logic [4:0] S_MOST  = 5'd2;
  localparam logic [4:0] S_APAG  = 5'd3;
  localparam logic [4:0] S_ESP   = 5'd4;
  localparam logic [4:0] S_REG   = 5'd5;
  localparam logic [4:0] S_COMP  = 5'd6;
  localparam logic [4:0] S_SOLTA = 5'd7;
  localparam logic [4:0] S_PROX  = 5'd8;
  localparam logic [4:0] S_GAN   = 5'd9;
  localparam logic [4:0] S_PERD  = 5'd10;
  localparam logic [4:0] S_GRAVA = 5'd11;

  logic       clock = 1'b0;
  logic       reset, iniciar, nivel;
  logic [3:0] botoes, leds;
  logic       vez_jogador, ganhou, perdeu, timeout, pronto;
  logic [1:0] rodada;
  logic [4:0] db_estado;

  jogo_sequencia_param #(
    .N(N),
    .DEPTH(DEPTH),
    .T_SHOW(T_SHOW),
    .T_TIMEOUT(T_TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .botoes(botoes),
    .nivel(nivel),
    .leds(leds),
    .vez_jogador(vez_jogador),
    .ganhou(ganhou),
    .perdeu(perdeu),
    .timeout(timeout),
    .pronto(pronto),
    .rodada(rodada),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1
  logic [15:0] mdl_lfsr;
  function automatic logic [15:0] lfsr_passo(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction
  always @(posedge clock or posedge reset) begin
    if (reset) mdl_lfsr <= 16'hACE1;
    else       mdl_lfsr <= lfsr_passo(mdl_lfsr);
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] seq [16];

  typedef struct {
    logic [4:0] estado;
    bit         ver_leds;
    logic [3:0] leds;
  } esp_t;
  esp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [3:0] oh(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  task automatic passo;
    @(posedge clock);
    #1;
  endtask

  task automatic sb_push(input logic [4:0] e, input bit v, input logic [3:0] l);
    esp_t x;
    x.estado   = e;
    x.ver_leds = v;
    x.leds     = l;
    sb.push_back(x);
  endtask

  task automatic drenar;
    esp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      check("sb_estado", db_estado, x.estado);
      if (x.ver_leds) check("sb_leds", leds, x.leds);
      passo();
    end
  endtask

  task automatic iniciar_jogo(input logic nv);
    nivel   = nv;
    iniciar = 1'b1;
    passo();
    check("prepara", db_estado, S_PREP);
    check("ganhou_clr", ganhou, 0);
    check("perdeu_clr", perdeu, 0);
    check("timeout_clr", timeout, 0);
`ifndef JOGO_MODO2_EN
    seq[0] = mdl_lfsr[1:0];
`endif
    iniciar = 1'b0;
    passo();
  endtask

  task automatic exibir(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (T_SHOW) sb_push(S_MOST, 1'b1, oh(seq[i]));
      repeat (T_SHOW) sb_push(S_APAG, 1'b1, 4'b0000);
    end
    drenar();
    check("espera", db_estado, S_ESP);
    check("vez", vez_jogador, 1);
  endtask

  task automatic apertar(input logic [3:0] b, input logic [4:0] meio,
                         input logic [4:0] prox, input int novo);
    botoes = b;
    #1;
    sb_push(S_ESP, 1'b1, b);
    sb_push(S_REG, 1'b0, 4'b0000);
    sb_push(meio, 1'b0, 4'b0000);
    drenar();
    check("apos_press", db_estado, prox);
    if (prox == S_GAN || prox == S_PERD) begin
      check("pronto", pronto, 1);
      check("leds_fim", leds, 0);
      check("vez_fim", vez_jogador, 0);
    end
    botoes = 4'b0000;
    if (prox == S_PROX) begin
      if (novo >= 0) seq[novo] = mdl_lfsr[1:0];
      passo();
      check("prox_mostra", db_estado, S_MOST);
    end else if (prox == S_SOLTA) begin
      passo();
      check("solta_espera", db_estado, S_ESP);
    end
  endtask

  task automatic rodada_lfsr(input int r, input int ult);
    exibir(r + 1);
    check("rodada", rodada, r);
    for (int a = 0; a <= r; a++) begin
      if (a < r)         apertar(oh(seq[a]), S_COMP, S_SOLTA, -1);
      else if (r == ult) apertar(oh(seq[a]), S_COMP, S_GAN, -1);
      else               apertar(oh(seq[a]), S_COMP, S_PROX, r + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] errado;
    reset   = 1'b1;
    iniciar = 1'b0;
    nivel   = 1'b0;
    botoes  = 4'b0000;
    #12;
    check("rst_leds", leds, 0);
    check("rst_vez", vez_jogador, 0);
    check("rst_ganhou", ganhou, 0);
    check("rst_perdeu", perdeu, 0);
    check("rst_timeout", timeout, 0);
    check("rst_pronto", pronto, 0);
    check("rst_rodada", rodada, 0);
    check("rst_estado", db_estado, S_INI);
    #5 reset = 1'b0;
    passo();
    check("inicial", db_estado, S_INI);

`ifndef JOGO_MODO2_EN
    // Two-round win at nivel=0
    iniciar_jogo(1'b0);
    rodada_lfsr(0, 1);
    rodada_lfsr(1, 1);
    check("win_ganhou", ganhou, 1);
    check("win_rodada", rodada, 1);
    passo();
    check("pronto_pulso", pronto, 0);
    check("ganhou_mantido", ganhou, 1);

    // Wrong button at addr 1 of round 1
    iniciar_jogo(1'b0);
    rodada_lfsr(0, 1);
    exibir(2);
    apertar(oh(seq[0]), S_COMP, S_SOLTA, -1);
    errado = seq[1] + 2'd1;
    apertar(oh(errado), S_COMP, S_PERD, -1);
    check("errado_perdeu", perdeu, 1);
    check("errado_timeout", timeout, 0);
    check("errado_ganhou", ganhou, 0);

    // No press: timeout exactly T_TIMEOUT cycles after ESPERA entry
    iniciar_jogo(1'b0);
    exibir(1);
    repeat (T_TIMEOUT - 1) passo();
    check("to_ainda_espera", db_estado, S_ESP);
    passo();
    check("to_estado", db_estado, S_PERD);
    check("to_perdeu", perdeu, 1);
    check("to_timeout", timeout, 1);
    check("to_pronto", pronto, 1);

    // Multi-bit press is always wrong
    iniciar_jogo(1'b0);
    exibir(1);
    apertar(4'b0011, S_COMP, S_PERD, -1);
    check("multi_perdeu", perdeu, 1);
    check("multi_timeout", timeout, 0);

    // Asynchronous reset in the middle of MOSTRA
    iniciar_jogo(1'b0);
    check("mid_mostra", db_estado, S_MOST);
    #2 reset = 1'b1;
    #1;
    check("arst_leds", leds, 0);
    check("arst_vez", vez_jogador, 0);
    check("arst_ganhou", ganhou, 0);
    check("arst_perdeu", perdeu, 0);
    check("arst_timeout", timeout, 0);
    check("arst_pronto", pronto, 0);
    check("arst_rodada", rodada, 0);
    check("arst_estado", db_estado, S_INI);
    #3 reset = 1'b0;
    passo();
    check("arst_inicial", db_estado, S_INI);

    // nivel=1: four rounds, then restart from GANHOU
    iniciar_jogo(1'b1);
    for (int r = 0; r < DEPTH; r++) rodada_lfsr(r, DEPTH - 1);
    check("n1_rodada", rodada, 3);
    check("n1_ganhou", ganhou, 1);
    iniciar_jogo(1'b0);
`else
    // Player-recorded sequence 1,2,4,8 over four rounds
    seq[0] = 2'd0;
    seq[1] = 2'd1;
    seq[2] = 2'd2;
    seq[3] = 2'd3;
    iniciar_jogo(1'b1);
    check("m2_espera", db_estado, S_ESP);
    check("m2_vez", vez_jogador, 1);
    apertar(oh(seq[0]), S_GRAVA, S_PROX, -1);
    check("m2_rodada", rodada, 1);
    for (int r = 1; r < DEPTH; r++) begin
      exibir(r);
      for (int a = 0; a < r; a++) apertar(oh(seq[a]), S_COMP, S_SOLTA, -1);
      if (r == DEPTH - 1) begin
        apertar(oh(seq[r]), S_GRAVA, S_GAN, -1);
      end else begin
        apertar(oh(seq[r]), S_GRAVA, S_PROX, -1);
        check("m2_rodada", rodada, r + 1);
      end
    end
    check("m2_ganhou", ganhou, 1);
    check("m2_rodada_fim", rodada, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
